// File: rtl/mem_wb_skid_reg_pkg.sv
// Shared definitions for the MEM->WB skid register: the occupancy state and the payload
// layout. The payload is packed as {WB_en, Mem_R_en, ALU_result, Mem_read_value, Dest}.
package mem_wb_skid_reg_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } skid_state_e;

  localparam int OFF_DEST = 0;

  function automatic int pld_width(input int bn, input int db);
    return 2 * bn + db + 2;
  endfunction

  function automatic int off_mrv(input int db);
    return db;
  endfunction

  function automatic int off_alu(input int bn, input int db);
    return db + bn;
  endfunction

  function automatic int off_mre(input int bn, input int db);
    return db + 2 * bn;
  endfunction

  function automatic int off_wbe(input int bn, input int db);
    return db + 2 * bn + 1;
  endfunction

endpackage

// File: rtl/mem_wb_skid_reg_register.sv
// Plain pipeline register with synchronous clear; freeze=1 holds the current contents.
module mem_wb_skid_reg_register #(
  parameter int BIT_NUMBER = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  freeze,
  input  logic [BIT_NUMBER-1:0] d_i,
  output logic [BIT_NUMBER-1:0] q_o
);

  logic [BIT_NUMBER-1:0] q_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      q_q <= '0;
    end else if (!freeze) begin
      q_q <= d_i;
    end
  end

  assign q_o = q_q;

endmodule

// File: rtl/mem_wb_skid_reg.sv
// MEM->WB pipeline register with valid/ready handshake and a 2-entry skid buffer.
// in_ready comes from a register, so WB back-pressure never reaches MEM combinationally.
module mem_wb_skid_reg
  import mem_wb_skid_reg_pkg::*;
#(
  parameter int BIT_NUMBER  = 32,
  parameter int DEST_BITS   = 4,
  parameter bit RESET_READY = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  freeze,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  WB_en_in,
  input  logic                  Mem_R_en_in,
  input  logic [BIT_NUMBER-1:0] ALU_result_in,
  input  logic [BIT_NUMBER-1:0] Mem_read_value_in,
  input  logic [DEST_BITS-1:0]  Dest_in,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  WB_en,
  output logic                  Mem_R_en,
  output logic [BIT_NUMBER-1:0] ALU_result,
  output logic [BIT_NUMBER-1:0] Mem_read_value,
  output logic [DEST_BITS-1:0]  Dest,
  output logic [BIT_NUMBER-1:0] WB_value
);

  localparam int PW      = pld_width(BIT_NUMBER, DEST_BITS);
  localparam int OFF_MRV = off_mrv(DEST_BITS);
  localparam int OFF_ALU = off_alu(BIT_NUMBER, DEST_BITS);
  localparam int OFF_MRE = off_mre(BIT_NUMBER, DEST_BITS);
  localparam int OFF_WBE = off_wbe(BIT_NUMBER, DEST_BITS);

  skid_state_e   state_q, state_d;
  logic          rdy_q, rdy_d;
  logic          main_en, skid_en, main_from_skid;
  logic          accept, consume;
  logic [PW-1:0] in_pld, main_d, main_q, skid_q;

  assign in_pld = {WB_en_in, Mem_R_en_in, ALU_result_in, Mem_read_value_in, Dest_in};

  assign in_ready  = rdy_q & ~freeze;
  assign out_valid = (state_q != ST_EMPTY);
  assign accept    = in_valid & in_ready;
  assign consume   = out_valid & out_ready & ~freeze;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_EMPTY;
      rdy_q   <= RESET_READY;
    end else begin
      state_q <= state_d;
      rdy_q   <= rdy_d;
    end
  end

  // Flush wins over freeze and accept; the slot payloads are left stale since out_valid masks them.
  always_comb begin
    state_d        = state_q;
    rdy_d          = rdy_q;
    main_en        = 1'b0;
    skid_en        = 1'b0;
    main_from_skid = 1'b0;
    if (flush) begin
      state_d = ST_EMPTY;
      rdy_d   = 1'b1;
    end else if (!freeze) begin
      unique case (state_q)
        ST_EMPTY: begin
          if (accept) begin
            main_en = 1'b1;
            state_d = ST_ONE;
          end
        end
        ST_ONE: begin
          if (accept && consume) begin
            main_en = 1'b1;
          end else if (accept) begin
            skid_en = 1'b1;
            state_d = ST_FULL;
          end else if (consume) begin
            state_d = ST_EMPTY;
          end
        end
        ST_FULL: begin
          if (consume) begin
            main_en        = 1'b1;
            main_from_skid = 1'b1;
            state_d        = ST_ONE;
          end
        end
        default: state_d = ST_EMPTY;
      endcase
      rdy_d = (state_d != ST_FULL);
    end
  end

  assign main_d = main_from_skid ? skid_q : in_pld;

  mem_wb_skid_reg_register #(.BIT_NUMBER(PW)) u_main (
    .clk    (clk),
    .rst    (rst),
    .freeze (~main_en),
    .d_i    (main_d),
    .q_o    (main_q)
  );

  mem_wb_skid_reg_register #(.BIT_NUMBER(PW)) u_skid (
    .clk    (clk),
    .rst    (rst),
    .freeze (~skid_en),
    .d_i    (in_pld),
    .q_o    (skid_q)
  );

  assign WB_en          = main_q[OFF_WBE] & out_valid;
  assign Mem_R_en       = main_q[OFF_MRE];
  assign ALU_result     = main_q[OFF_ALU +: BIT_NUMBER];
  assign Mem_read_value = main_q[OFF_MRV +: BIT_NUMBER];
  assign Dest           = main_q[OFF_DEST +: DEST_BITS];
  assign WB_value       = Mem_R_en ? Mem_read_value : ALU_result;

endmodule

// File: tb/tb_mem_wb_skid_reg.sv
// Directed vector bench for mem_wb_skid_reg: each row is driven for one cycle and the
// outputs are checked on the falling edge, before the row's rising edge commits.
module tb_mem_wb_skid_reg;

  localparam int BN = 32;
  localparam int DB = 4;

  logic          clk = 1'b1;
  logic          rst, flush, freeze, in_valid, out_ready;
  logic          in_ready, out_valid;
  logic          WB_en_in, Mem_R_en_in, WB_en, Mem_R_en;
  logic [BN-1:0] ALU_result_in, Mem_read_value_in, ALU_result, Mem_read_value, WB_value;
  logic [DB-1:0] Dest_in, Dest;

  always #5 clk = ~clk;

  mem_wb_skid_reg #(.BIT_NUMBER(BN), .DEST_BITS(DB), .RESET_READY(1'b1)) dut (
    .clk               (clk),
    .rst               (rst),
    .flush             (flush),
    .freeze            (freeze),
    .in_valid          (in_valid),
    .in_ready          (in_ready),
    .WB_en_in          (WB_en_in),
    .Mem_R_en_in       (Mem_R_en_in),
    .ALU_result_in     (ALU_result_in),
    .Mem_read_value_in (Mem_read_value_in),
    .Dest_in           (Dest_in),
    .out_valid         (out_valid),
    .out_ready         (out_ready),
    .WB_en             (WB_en),
    .Mem_R_en          (Mem_R_en),
    .ALU_result        (ALU_result),
    .Mem_read_value    (Mem_read_value),
    .Dest              (Dest),
    .WB_value          (WB_value)
  );

  // chk: 0 = no check, 1 = handshake/WB_en only, 2 = also the head payload
  typedef struct {
    logic          rst, fl, fz, iv, ordy, wbe, mre;
    logic [BN-1:0] alu, mrv;
    logic [DB-1:0] dest;
    int            chk;
    logic          ov, ir, ewb, emre;
    logic [BN-1:0] ealu, emrv;
    logic [DB-1:0] edest;
  } vec_t;

  int n_vec  = 0;
  int n_cmp  = 0;
  int n_miss = 0;

  function automatic vec_t mk(input logic r, fl, fz, iv, ordy, wbe, mre,
                              input logic [BN-1:0] alu, mrv, input logic [DB-1:0] dest,
                              input int chk, input logic ov, ir, ewb, emre,
                              input logic [BN-1:0] ealu, emrv, input logic [DB-1:0] edest);
    vec_t v;
    v.rst = r; v.fl = fl; v.fz = fz; v.iv = iv; v.ordy = ordy; v.wbe = wbe; v.mre = mre;
    v.alu = alu; v.mrv = mrv; v.dest = dest; v.chk = chk;
    v.ov = ov; v.ir = ir; v.ewb = ewb; v.emre = emre;
    v.ealu = ealu; v.emrv = emrv; v.edest = edest;
    return v;
  endfunction

  task automatic cmp(input string name, input logic [BN-1:0] act, input logic [BN-1:0] req);
    n_cmp++;
    if (act !== req) begin
      n_miss++;
      $display("FAIL %s @%0t: got 0x%0h, expected 0x%0h", name, $time, act, req);
    end
  endtask

  task automatic drive(input vec_t v);
    rst = v.rst; flush = v.fl; freeze = v.fz; in_valid = v.iv; out_ready = v.ordy;
    WB_en_in = v.wbe; Mem_R_en_in = v.mre; ALU_result_in = v.alu;
    Mem_read_value_in = v.mrv; Dest_in = v.dest;
  endtask

  task automatic check(input int idx, input vec_t v);
    string t;
    t = $sformatf("v%0d", idx);
    if (v.chk >= 1) begin
      cmp({t, ".out_valid"}, BN'(out_valid), BN'(v.ov));
      cmp({t, ".in_ready"},  BN'(in_ready),  BN'(v.ir));
      cmp({t, ".WB_en"},     BN'(WB_en),     BN'(v.ewb));
    end
    if (v.chk >= 2) begin
      cmp({t, ".Dest"},           BN'(Dest),      BN'(v.edest));
      cmp({t, ".ALU_result"},     ALU_result,     v.ealu);
      cmp({t, ".Mem_read_value"}, Mem_read_value, v.emrv);
      cmp({t, ".Mem_R_en"},       BN'(Mem_R_en),  BN'(v.emre));
      cmp({t, ".WB_value"},       WB_value,       v.emre ? v.emrv : v.ealu);
    end
  endtask

  vec_t tbl[36];

  initial begin
    //              rst fl fz iv or we mr alu    mrv     dst  chk ov ir wb mr ealu    emrv    edst
    // reset held two cycles with in_valid high
    tbl[0]  = mk(1, 0, 0, 1, 0, 1, 1, 'hFF,  'hEE,   4'hF, 0, 0, 0, 0, 0, 0,      0,      0);
    tbl[1]  = mk(1, 0, 0, 1, 0, 1, 1, 'hFF,  'hEE,   4'hF, 2, 0, 1, 0, 0, 0,      0,      0);
    tbl[2]  = mk(0, 0, 0, 0, 1, 0, 0, 0,     0,      0,    2, 0, 1, 0, 0, 0,      0,      0);
    // streaming four entries with out_ready=1
    tbl[3]  = mk(0, 0, 0, 1, 1, 1, 0, 'h10,  0,      4'd1, 1, 0, 1, 0, 0, 0,      0,      0);
    tbl[4]  = mk(0, 0, 0, 1, 1, 1, 0, 'h20,  0,      4'd2, 2, 1, 1, 1, 0, 'h10,   0,      4'd1);
    tbl[5]  = mk(0, 0, 0, 1, 1, 1, 0, 'h30,  0,      4'd3, 2, 1, 1, 1, 0, 'h20,   0,      4'd2);
    tbl[6]  = mk(0, 0, 0, 1, 1, 1, 0, 'h40,  0,      4'd4, 2, 1, 1, 1, 0, 'h30,   0,      4'd3);
    tbl[7]  = mk(0, 0, 0, 0, 1, 0, 0, 0,     0,      0,    2, 1, 1, 1, 0, 'h40,   0,      4'd4);
    tbl[8]  = mk(0, 0, 0, 0, 1, 0, 0, 0,     0,      0,    1, 0, 1, 0, 0, 0,      0,      0);
    // back-pressure: 5, 6 fill both slots, 7 is held off
    tbl[9]  = mk(0, 0, 0, 1, 0, 1, 0, 'h50,  0,      4'd5, 1, 0, 1, 0, 0, 0,      0,      0);
    tbl[10] = mk(0, 0, 0, 1, 0, 1, 0, 'h60,  0,      4'd6, 2, 1, 1, 1, 0, 'h50,   0,      4'd5);
    tbl[11] = mk(0, 0, 0, 1, 0, 1, 0, 'h70,  0,      4'd7, 2, 1, 0, 1, 0, 'h50,   0,      4'd5);
    tbl[12] = mk(0, 0, 0, 1, 1, 1, 0, 'h70,  0,      4'd7, 2, 1, 0, 1, 0, 'h50,   0,      4'd5);
    tbl[13] = mk(0, 0, 0, 1, 1, 1, 0, 'h70,  0,      4'd7, 2, 1, 1, 1, 0, 'h60,   0,      4'd6);
    tbl[14] = mk(0, 0, 0, 0, 1, 0, 0, 0,     0,      0,    2, 1, 1, 1, 0, 'h70,   0,      4'd7);
    tbl[15] = mk(0, 0, 0, 0, 1, 0, 0, 0,     0,      0,    1, 0, 1, 0, 0, 0,      0,      0);
    // flush while FULL with Dest=9 offered in the same cycle
    tbl[16] = mk(0, 0, 0, 1, 0, 1, 0, 'h80,  0,      4'd8, 1, 0, 1, 0, 0, 0,      0,      0);
    tbl[17] = mk(0, 0, 0, 1, 0, 1, 0, 'hA0,  0,      4'hA, 2, 1, 1, 1, 0, 'h80,   0,      4'd8);
    tbl[18] = mk(0, 1, 0, 1, 0, 1, 0, 'h90,  0,      4'd9, 2, 1, 0, 1, 0, 'h80,   0,      4'd8);
    tbl[19] = mk(0, 0, 0, 0, 1, 0, 0, 0,     0,      0,    1, 0, 1, 0, 0, 0,      0,      0);
    tbl[20] = mk(0, 0, 0, 0, 1, 0, 0, 0,     0,      0,    1, 0, 1, 0, 0, 0,      0,      0);
    // freeze for 3 cycles over a load head
    tbl[21] = mk(0, 0, 0, 1, 0, 1, 1, 'h1234,'hDEAD, 4'd3, 1, 0, 1, 0, 0, 0,      0,      0);
    tbl[22] = mk(0, 0, 1, 1, 1, 1, 0, 'h55,  0,      4'd4, 2, 1, 0, 1, 1, 'h1234, 'hDEAD, 4'd3);
    tbl[23] = mk(0, 0, 1, 1, 1, 1, 0, 'h55,  0,      4'd4, 2, 1, 0, 1, 1, 'h1234, 'hDEAD, 4'd3);
    tbl[24] = mk(0, 0, 1, 1, 1, 1, 0, 'h55,  0,      4'd4, 2, 1, 0, 1, 1, 'h1234, 'hDEAD, 4'd3);
    tbl[25] = mk(0, 0, 0, 0, 1, 0, 0, 0,     0,      0,    2, 1, 1, 1, 1, 'h1234, 'hDEAD, 4'd3);
    tbl[26] = mk(0, 0, 0, 0, 1, 0, 0, 0,     0,      0,    1, 0, 1, 0, 0, 0,      0,      0);
    // reset while FULL, then Dest=2 passes with one cycle latency
    tbl[27] = mk(0, 0, 0, 1, 0, 1, 0, 'hB0,  0,      4'hB, 1, 0, 1, 0, 0, 0,      0,      0);
    tbl[28] = mk(0, 0, 0, 1, 0, 1, 0, 'hC0,  0,      4'hC, 2, 1, 1, 1, 0, 'hB0,   0,      4'hB);
    tbl[29] = mk(1, 0, 0, 1, 1, 1, 0, 'hD0,  0,      4'hD, 2, 1, 0, 1, 0, 'hB0,   0,      4'hB);
    tbl[30] = mk(0, 0, 0, 1, 0, 1, 0, 'h22,  0,      4'd2, 2, 0, 1, 0, 0, 0,      0,      0);
    tbl[31] = mk(0, 0, 0, 0, 1, 0, 0, 0,     0,      0,    2, 1, 1, 1, 0, 'h22,   0,      4'd2);
    tbl[32] = mk(0, 0, 0, 0, 1, 0, 0, 0,     0,      0,    1, 0, 1, 0, 0, 0,      0,      0);
    // valid entry that does not write the register file
    tbl[33] = mk(0, 0, 0, 1, 1, 0, 0, 'h77,  'h99,   4'd6, 1, 0, 1, 0, 0, 0,      0,      0);
    tbl[34] = mk(0, 0, 0, 0, 1, 0, 0, 0,     0,      0,    2, 1, 1, 0, 0, 'h77,   'h99,   4'd6);
    tbl[35] = mk(0, 0, 0, 0, 1, 0, 0, 0,     0,      0,    1, 0, 1, 0, 0, 0,      0,      0);

    for (int i = 0; i < 36; i++) begin
      drive(tbl[i]);
      @(negedge clk);
      check(i, tbl[i]);
      n_vec++;
      @(posedge clk);
      #1;
    end

    // flush together with freeze: flush wins, the frozen head is dropped
    drive(mk(0, 0, 0, 1, 0, 1, 0, 'h31, 0, 4'd1, 0, 0, 0, 0, 0, 0, 0, 0));
    @(posedge clk); #1;
    drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    @(negedge clk);
    cmp("ff.pre_out_valid", BN'(out_valid), BN'(1'b1));
    cmp("ff.pre_Dest",      BN'(Dest),      BN'(4'd1));
    n_vec++;
    flush = 1'b1; freeze = 1'b1; in_valid = 1'b1; Dest_in = 4'd9;
    @(negedge clk);
    cmp("ff.frz_in_ready",  BN'(in_ready),  BN'(1'b0));
    n_vec++;
    @(posedge clk); #1;
    flush = 1'b0; freeze = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    cmp("ff.out_valid", BN'(out_valid), BN'(1'b0));
    cmp("ff.WB_en",     BN'(WB_en),     BN'(1'b0));
    cmp("ff.in_ready",  BN'(in_ready),  BN'(1'b1));
    n_vec++;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: bench did not finish, got running, expected done");
    $fatal(1, "timeout");
  end

endmodule
